// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit for the E stage.
// Results are computed at issue and released after a fixed busy latency.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic        start,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CLOG = $clog2(MAXC + 1);
    localparam int CW   = (CLOG < 4) ? 4 : CLOG;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_res_hi;
    logic [31:0]   r_res_lo;

    logic w_idle;
    logic w_start_eff;
    logic w_done;
    logic w_op_mul;
    logic w_op_div;
    logic w_signed;
    logic w_mthi;
    logic w_mtlo;

    always_comb begin
        w_op_mul = 1'b0;
        w_op_div = 1'b0;
        w_signed = 1'b0;
        w_mthi   = 1'b0;
        w_mtlo   = 1'b0;
        case (md_op)
            3'b001:  w_mthi = 1'b1;
            3'b010:  w_mtlo = 1'b1;
            3'b011:  w_op_mul = 1'b1;
            3'b100: begin
                w_op_mul = 1'b1;
                w_signed = 1'b1;
            end
            3'b101:  w_op_div = 1'b1;
            3'b110: begin
                w_op_div = 1'b1;
                w_signed = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_idle      = (r_state == S_IDLE);
    assign w_start_eff = start && !flush && w_idle;
    assign w_done      = !w_idle && (r_cnt == CW'(1));

    // Product
    logic        [63:0] w_prod_u;
    logic signed [63:0] w_prod_s;
    logic        [63:0] w_prod;

    assign w_prod_u = {32'd0, a} * {32'd0, b};
    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod   = w_signed ? w_prod_s : w_prod_u;

    // Sign-magnitude division; INT_MIN / -1 falls out as 0x80000000 rem 0
    logic        w_neg_a;
    logic        w_neg_b;
    logic        w_div0;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_divisor;
    logic [31:0] w_uq;
    logic [31:0] w_ur;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_neg_a   = w_signed && a[31];
    assign w_neg_b   = w_signed && b[31];
    assign w_div0    = (b == 32'd0);
    assign w_abs_a   = w_neg_a ? (32'd0 - a) : a;
    assign w_abs_b   = w_neg_b ? (32'd0 - b) : b;
    assign w_divisor = w_div0 ? 32'd1 : w_abs_b;
    assign w_uq      = w_abs_a / w_divisor;
    assign w_ur      = w_abs_a % w_divisor;
    assign w_quo     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
    assign w_rem     = w_neg_a ? (32'd0 - w_ur) : w_ur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_eff && w_op_mul) begin
                    w_next = S_MUL;
                end else if (w_start_eff && w_op_div) begin
                    w_next = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (w_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = !w_idle;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else if (w_start_eff) begin
            if (w_op_mul) begin
                r_res_hi <= w_prod[63:32];
                r_res_lo <= w_prod[31:0];
                r_cnt    <= CW'(MULT_CYCLES);
            end
            if (w_op_div) begin
                // Divide by zero retires the current HI/LO unchanged
                r_res_hi <= w_div0 ? r_hi : w_rem;
                r_res_lo <= w_div0 ? r_lo : w_quo;
                r_cnt    <= CW'(DIV_CYCLES);
            end
            if (w_mthi) begin
                r_hi <= a;
            end
            if (w_mtlo) begin
                r_lo <= a;
            end
        end else if (!w_idle) begin
            r_cnt <= r_cnt - CW'(1);
            if (w_done) begin
                r_hi <= r_res_hi;
                r_lo <= r_res_lo;
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
